// File: rtl/image_rom_arbiter.sv
// rtl/image_rom_arbiter.sv - shares one registered 32x32 image ROM between N_REQ sprite drawers
// Define IMAGE_ROM_ARB_FIXED_PRIO_EN for lowest-index-wins priority; default build is round-robin.
module image_rom_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [10*N_REQ-1:0] addr,
  output logic [N_REQ-1:0]    gnt,
  output logic [9:0]          rom_address,
  input  logic [11:0]         rom_rgb,
  output logic [N_REQ-1:0]    rd_valid,
  output logic [11:0]         rd_data
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDW-1:0]   w_win;
  logic             w_accept;
  logic [N_REQ-1:0] w_gnt;
  logic [9:0]       w_win_addr;

  logic [9:0]       r_rom_address;
  logic             r_s1_valid;
  logic [IDW-1:0]   r_s1_id;
  logic             r_s2_valid;
  logic [IDW-1:0]   r_s2_id;

`ifdef IMAGE_ROM_ARB_FIXED_PRIO_EN
  // Scan high to low so the lowest asserted index is the last (winning) assignment.
  always_comb begin
    w_win    = '0;
    w_accept = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_win    = IDW'(i);
        w_accept = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] r_rr_ptr;

  // Offsets are scanned far-to-near so the requester closest after r_rr_ptr wins.
  always_comb begin
    logic [IDW-1:0] v_idx;
    v_idx    = '0;
    w_win    = '0;
    w_accept = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      v_idx = IDW'((int'(r_rr_ptr) + k) % N_REQ);
      if (req[v_idx]) begin
        w_win    = v_idx;
        w_accept = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= IDW'(N_REQ - 1);
    end else if (w_accept) begin
      r_rr_ptr <= w_win;
    end
  end
`endif

  always_comb begin
    w_gnt = '0;
    if (w_accept && rst_n) begin
      w_gnt[w_win] = 1'b1;
    end
  end

  always_comb begin
    w_win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_win_addr = addr[10*i +: 10];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_address <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_id       <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_id       <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_rom_address <= w_win_addr;
        r_s1_id       <= w_win;
      end
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
    end
  end

  always_comb begin
    rd_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rd_valid[i] = r_s2_valid && (r_s2_id == IDW'(i));
    end
  end

  assign gnt         = w_gnt;
  assign rom_address = r_rom_address;
  assign rd_data     = r_s2_valid ? rom_rgb : 12'h000;

endmodule
